// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================
// serial_subtractor_pkg: shared state encoding and default width
// Rev 1.0
// ============================================================
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/full_subtractor_1bit.sv
`default_nettype none
// ============================================================
// full_subtractor_1bit: combinational d = a - b - bin with borrow-out
// Rev 1.0
// ============================================================
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================
// serial_subtractor: bit-serial Diff = A - B - Bin, LSB first
// Rev 1.0
// ============================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             borrow_next;

  full_subtractor_1bit u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (borrow_next)
  );

  // DONE accepts a new start just like IDLE, enabling back-to-back issue
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign cnt_next = cnt + CNT_W'(1);
  assign last_bit = (state == S_RUN) && (cnt_next == CNT_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = start ? S_RUN : S_IDLE;
      S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
    end else if (accept) begin
      sa  <= A;
      sb  <= B;
      br  <= Bin;
      cnt <= '0;
    end else if (state == S_RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= borrow_next;
      sd  <= {d_bit, sd[WIDTH-1:1]};
      cnt <= cnt_next;
      // Results are published only here, so partial bits never reach Diff
      if (last_bit) begin
        Diff <= {d_bit, sd[WIDTH-1:1]};
        Bout <= borrow_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================
// tb_serial_subtractor: directed and exhaustive check against a countdown model
// Rev 1.0
// ============================================================
module tb_serial_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;
  bit end_req = 1'b0;

  // Literal expectations {Diff, Bout} for directed operations, consumed in order on done
  logic [W:0] lit_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .Diff  (diff),
    .Bout  (bout)
  );

  always #5 clk = ~clk;

  // Behavioural model: an operation occupies W edges after its accepting edge
  int           left;
  logic         m_busy;
  logic         m_done;
  logic [W-1:0] m_diff;
  logic         m_bout;
  logic [W-1:0] p_diff;
  logic         p_bout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left   = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_diff = '0;
      m_bout = 1'b0;
    end else begin
      m_done = 1'b0;
      if (left > 0) begin
        left = left - 1;
        if (left == 0) begin
          m_diff = p_diff;
          m_bout = p_bout;
          m_done = 1'b1;
        end
      end else if (start) begin
        p_diff = W'((int'(a) - int'(b) - int'(bin)) & MASK);
        p_bout = (int'(a) < int'(b) + int'(bin));
        left   = W;
      end
      m_busy = (left > 0);
    end
  end

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
    end
  endtask

  always begin
    logic [W:0] lit;
    @(negedge clk or negedge rst_n);
    #1;
    if (end_req) begin
      cmp("lit_consumed", lit_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    cmp("busy", int'(busy), int'(m_busy));
    cmp("done", int'(done), int'(m_done));
    cmp("diff", int'(diff), int'(m_diff));
    cmp("bout", int'(bout), int'(m_bout));
    if (done && lit_q.size() > 0) begin
      lit = lit_q.pop_front();
      cmp("lit_diff", int'(diff), int'(lit[W:1]));
      cmp("lit_bout", int'(bout), int'(lit[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns in its DONE cycle with start low
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tbin, input logic [W-1:0] ed, input logic eb);
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    lit_q.push_back({ed, eb});
    tick();
    start = 1'b0;
    repeat (W) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    op(4'h7, 4'h3, 1'b0, 4'h4, 1'b0);
    repeat (2) tick();
    op(4'h3, 4'hC, 1'b0, 4'h7, 1'b1);
    repeat (2) tick();
    op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1);
    repeat (2) tick();

    // start while busy must be ignored
    a = 4'hF; b = 4'hF; bin = 1'b0; start = 1'b1;
    lit_q.push_back({4'h0, 1'b0});
    tick();
    a = 4'h1; b = 4'h0;
    repeat (2) tick();
    start = 1'b0;
    repeat (2) tick();
    repeat (10) tick();

    // back-to-back: second operands presented in the DONE cycle
    a = 4'h9; b = 4'h2; bin = 1'b0; start = 1'b1;
    lit_q.push_back({4'h7, 1'b0});
    lit_q.push_back({4'h9, 1'b1});
    tick();
    repeat (W) tick();
    a = 4'h2; b = 4'h9;
    tick();
    start = 1'b0;
    repeat (W) tick();
    repeat (2) tick();

    // reset two cycles into an operation abandons it
    a = 4'h8; b = 4'h1; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    op(4'h5, 4'h6, 1'b0, 4'hF, 1'b1);
    repeat (2) tick();

    // exhaustive, start held high throughout; junk operands while running
    start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      a   = W'(i >> 5);
      b   = W'((i >> 1) & MASK);
      bin = i[0];
      tick();
      a   = W'($urandom_range(0, MASK));
      b   = W'($urandom_range(0, MASK));
      bin = 1'($urandom_range(0, 1));
      repeat (W) tick();
    end
    start = 1'b0;
    repeat (3) tick();
    end_req = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtractor that computes Diff = A - B - Bin, LSB first, using one full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's combinational adders. It trades WIDTH cycles of latency for a single-bit datapath. A start/busy/done handshake sits in front, so a controller or testbench can issue operations back-to-back.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2).
CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; not overridden).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request an operation; sampled on the rising edge while ready.
A  input  WIDTH  minuend; captured on the accepted start edge.
B  input  WIDTH  subtrahend; captured on the accepted start edge.
Bin  input  1  borrow-in; captured on the accepted start edge.
busy  output  1  high while an operation is in progress (state RUN).
done  output  1  one-cycle pulse when Diff/Bout have just been updated.
Diff  output  WIDTH  registered difference, modulo 2^WIDTH.
Bout  output  1  registered borrow-out; 1 when A < B + Bin (unsigned).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, at any time):
  - state goes to IDLE;
  - busy, done, Bout, Diff, counter, shift registers and the borrow flop all go to 0.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: load A into sa, B into sb, Bin into the borrow flop br; cnt=0; go to RUN.
- RUN, one bit per edge:
  - d = sa[0]^sb[0]^br.
  - br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sa and sb shift right; d shifts into the MSB of the partial-difference register sd; cnt++.
  - On the edge where cnt reaches WIDTH:
    - Diff <= final sd (including this bit);
    - Bout <= br_next;
    - done <= 1;
    - state goes to DONE.
- DONE:
  - Lasts one cycle; done=1 and busy=0.
  - Next edge: if start=1, accept a new operation exactly as from IDLE (back-to-back); otherwise go to IDLE.
  - done returns to 0 unless a new completion occurs.
- Latency:
  - Start is accepted at edge k; done is high in the cycle after edge k+WIDTH.
  - Minimum issue interval is WIDTH+1 cycles.
- Handshake rules:
  - start is ignored while busy=1. Operands presented during RUN have no effect.
  - A, B and Bin need to be valid only on the accepting edge.
- Output stability:
  - Diff and Bout change only on a completion edge or on reset, and hold between operations.
  - Intermediate bits are never visible on Diff.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Bout is identical to the inverted carry-out of A + ~B + ~Bin.
  - A==B with Bin=1 gives Diff = all ones and Bout=1.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and the default WIDTH.
- One natural sub-module: full_subtractor_1bit (inputs a, b, bin; outputs d, bout; purely combinational). It is instantiated once in the datapath.
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- Reset, then A=4'h7, B=4'h3, Bin=0, start for 1 cycle:
  - busy high for 4 cycles;
  - then done pulse with Diff=4'h4, Bout=0.
- A=4'h3, B=4'hC, Bin=0 -> Diff=4'h7, Bout=1. Repeat with A=4'h0, B=4'h0, Bin=1 -> Diff=4'hF, Bout=1.
- A=4'hF, B=4'hF, Bin=0 -> Diff=4'h0, Bout=0.
  - While busy, drive start=1 with A=4'h1, B=4'h0: ignored, result unchanged.
  - Diff holds 4'h0 for 10 idle cycles afterwards.
- Back-to-back issue:
  - Hold start=1 with A=4'h9, B=4'h2, then present A=4'h2, B=4'h9 in the DONE cycle.
  - Expect done pulses 5 cycles apart: Diff=4'h7, Bout=0, then Diff=4'h9, Bout=1.
- Assert rst_n low 2 cycles into an operation (A=4'h8, B=4'h1):
  - all outputs 0 immediately (asynchronous), no done pulse afterwards;
  - the next start completes normally.
- Exhaustive self-check, all 512 (A, B, Bin) combinations:
  - Diff and Bout must match a reference model ((A-B-Bin) mod 16, A<B+Bin);
  - done must occur exactly 5 cycles after each accepted start.
